// File: rtl/atm_cell_arbiter_if.sv
// Queue-side and output-side signal bundle for atm_cell_arbiter.
// master = arbiter, slave = FIFO bank plus output stage.
interface atm_cell_arbiter_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]        q_cell_rdy;
  logic [N-1:0]        q_empty;
  logic [N*DATA_W-1:0] q_dout;
  logic [N-1:0]        q_read;
  logic                out_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                out_sop;
  logic                out_eop;
  logic [PW-1:0]       out_port;
  logic                out_abort;

  modport master (
    input  q_cell_rdy, q_empty, q_dout, out_ready,
    output q_read, out_valid, out_data,
    output out_sop, out_eop, out_port, out_abort
  );

  modport slave (
    output q_cell_rdy, q_empty, q_dout, out_ready,
    input  q_read, out_valid, out_data,
    input  out_sop, out_eop, out_port, out_abort
  );
endinterface

// File: rtl/atm_cell_arbiter.sv
// Whole-cell round-robin arbiter from N byte FIFOs to one output port.
// ATM_ARB_STRICT_PRI_EN selects fixed lowest-index priority instead.
module atm_cell_arbiter #(
  parameter int N        = 4,
  parameter int DATA_W   = 8,
  parameter int CELL_LEN = 53
) (
  input logic clk,
  input logic rst,
  atm_cell_arbiter_if.master bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [5:0] LEN  = 6'(CELL_LEN);
  localparam logic [5:0] LAST = 6'(CELL_LEN - 1);

  if (CELL_LEN > 63 || CELL_LEN < 2) begin : g_bad_len
    $error("CELL_LEN must be in 2..63");
  end

  logic [1:0]    r_state;
  logic [5:0]    r_cnt;
  logic [PW-1:0] r_gnt;
  logic          r_valid;
  logic          r_sop;
  logic          r_eop;

  logic [PW-1:0] w_gnt;
  logic [PW-1:0] w_nxt;
  logic [N-1:0]  w_qrd;
  logic          w_req;
  logic          w_empty;
  logic          w_rd;
  logic          w_last;

  assign w_req   = |bus.q_cell_rdy;
  assign w_empty = bus.q_empty[r_gnt];
  assign w_rd    = (r_state == S_READ)
                && (r_cnt < LEN)
                && !w_empty;
  assign w_last  = w_rd && (r_cnt == LAST);
  assign w_nxt   = (r_gnt == PW'(N - 1))
                 ? '0 : r_gnt + 1'b1;

`ifdef ATM_ARB_STRICT_PRI_EN
  always_comb begin
    w_gnt = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.q_cell_rdy[k]) w_gnt = PW'(k);
    end
  end
`else
  logic [PW-1:0] r_rr;
  logic [PW-1:0] w_idx;
  logic          w_hit;

  // first requester at or above r_rr, wrapping
  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    w_hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(r_rr) + k) % N);
      if (!w_hit && bus.q_cell_rdy[w_idx]) begin
        w_hit = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr <= '0;
    end else if (r_state == S_READ) begin
      if (w_empty || w_last) r_rr <= w_nxt;
    end
  end
`endif

  always_comb begin
    w_qrd = '0;
    if (w_rd) w_qrd[r_gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end else begin
      r_valid <= w_rd;
      r_sop   <= w_rd && (r_cnt == 6'd0);
      r_eop   <= w_last;
      unique case (r_state)
        S_IDLE: begin
          if (bus.out_ready && w_req) begin
            r_state <= S_READ;
            r_gnt   <= w_gnt;
            r_cnt   <= '0;
          end
        end
        S_READ: begin
          if (w_empty) begin
            r_state <= S_IDLE;
          end else if (w_rd) begin
            r_cnt <= r_cnt + 6'd1;
            if (w_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.q_read    = w_qrd;
  assign bus.out_valid = r_valid;
  assign bus.out_sop   = r_sop;
  assign bus.out_eop   = r_eop;
  assign bus.out_port  = r_gnt;
  assign bus.out_data  =
    bus.q_dout[int'(r_gnt)*DATA_W +: DATA_W];
  // underrun flagged alongside the last byte read
  assign bus.out_abort = (r_state == S_READ)
                      && w_empty;
endmodule

// File: doc/atm_cell_arbiter.md
# atm_cell_arbiter

Round-robin cell arbiter in the ATM switch datapath. It shares one output port between N input-port byte FIFOs (8-bit, 106-deep, two-cell queues) and moves whole 53-byte cells, never interleaved bytes. Each cell is read from the granted queue with a 53-cycle `read` burst, and the bytes are forwarded with start-of-cell and end-of-cell markers. The block sits between the per-port input FIFOs and the switch output stage.

## Interface
- `N`, 4: number of input queues (2..8).
- `DATA_W`, 8: byte width; must match the FIFO data width.
- `CELL_LEN`, 53: bytes per cell.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `q_cell_rdy`  in  N  queue i holds at least one complete cell (from the upstream cell counter).
- `q_empty`  in  N  FIFO `empty` per queue.
- `q_dout`  in  N*DATA_W  FIFO `fifo_dout` per queue; queue i occupies bits [i*DATA_W +: DATA_W].
- `q_read`  out  N  FIFO `read` strobe; one-hot or zero.
- `out_ready`  in  1  downstream can accept a full cell; sampled only at the grant decision.
- `out_valid`  out  1  `out_data` is valid this cycle.
- `out_data`  out  DATA_W  cell byte.
- `out_sop` / `out_eop`  out  1  first byte / last byte of the cell; each qualified by `out_valid`.
- `out_port`  out  $clog2(N)  index of the queue being forwarded; held stable for the whole cell.
- `out_abort`  out  1  one-cycle pulse when a cell is truncated by underrun.

## Operation
- States:
  - IDLE: decide a grant.
  - READ: issue the 53 reads.
  - DRAIN: forward the final byte.
- IDLE → READ when `out_ready` is 1 and `q_cell_rdy` is non-zero.
  - Grant `g` is the first set request at or after `rr_ptr`, searching cyclically upward and wrapping N-1 → 0.
  - `g` and `out_port` are latched; the byte counter is cleared to 0.
- READ: assert `q_read[g]` every cycle while the counter is below CELL_LEN; increment the counter per read.
  - After the read with counter = CELL_LEN-1: go to DRAIN and set `rr_ptr` to (g+1) mod N.
- DRAIN: one cycle, then → IDLE.
- Output path:
  - `out_data` = the `q_dout` slice for `g` (combinational mux); `out_valid` = `q_read[g]` delayed by one cycle.
  - `out_sop` marks the byte read at counter 0; `out_eop` marks the byte read at counter CELL_LEN-1.
- Underrun: `q_empty[g]` = 1 in a READ cycle →
  - no read that cycle;
  - `out_abort` pulses the next cycle, together with `out_valid` of the last byte actually read, if any;
  - `out_eop` is not asserted;
  - `rr_ptr` advances as for a normal completion;
  - → IDLE.
- `q_cell_rdy` and `out_ready` changes during READ/DRAIN are ignored.
- Byte counter is 6 bits. CELL_LEN ≤ 63 is enforced by an elaboration check.

## Timing
- Reset:
  - state IDLE, `rr_ptr`=0, counter 0;
  - `q_read`=0, `out_valid`=0, `out_sop`=0, `out_eop`=0, `out_abort`=0, `out_port`=0;
  - `out_data` is don't-care while `out_valid`=0.
- Grant decided in cycle T.
  - `q_read[g]` high for T+1..T+53.
  - `out_valid` high for T+2..T+54: `out_sop` at T+2, `out_eop` at T+54.
  - DRAIN is T+54; IDLE at T+55.
  - Earliest next grant is decided at T+55 and its first read is at T+56.
- Cell service period is therefore 55 cycles per cell, all queues saturated.
- `rst` asserted mid-cell: at the next edge all state and outputs return to reset values and `q_read` drops immediately. The partial cell is discarded with no `out_eop` and no `out_abort`. Queue flushing is upstream's responsibility.

## Configuration
- `ATM_ARB_STRICT_PRI_EN` defined: fixed priority.
  - The lowest-index requesting queue always wins.
  - `rr_ptr` is not implemented and the grant ignores history.
- Undefined (default): round-robin as described above.

## Test plan
- Reset, then `q_cell_rdy`=4'b0001, `out_ready`=1 →
  - `q_read[0]` for exactly 53 cycles;
  - 53 `out_valid` bytes matching the FIFO contents;
  - `out_sop` on byte 1, `out_eop` on byte 53;
  - `out_port`=0.
- `q_cell_rdy`=4'b1111 held for 8 cells → grants in order 0,1,2,3,0,1,2,3, each cell 55 cycles apart. With `ATM_ARB_STRICT_PRI_EN` defined: all 8 grants go to 0.
- Only queue 2 requesting with `rr_ptr`=3 → search wraps and grants 2; afterwards `rr_ptr`=3.
- `q_cell_rdy`=4'b0010 with `out_ready`=0 for 10 cycles → no `q_read`; first read occurs 1 cycle after `out_ready` rises.
- Queue 1 granted, `q_empty[1]` forced high after 20 reads →
  - 20 `out_valid` bytes;
  - `out_abort` pulse coincident with byte 20;
  - no `out_eop`;
  - next grant goes to queue 2.
- `rst` at read 30 of a cell → `q_read`=0 and `out_valid`=0 one edge later; a subsequent request from queue 0 is granted with `rr_ptr`=0.
